// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with architectural HI/LO
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic        commit_q, commit_d;

  logic        start;
  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor_nz, quot_s, rem_s, quot_u, rem_u;

  assign busy     = (state_q == RUN);
  assign start    = (E_md_op >= 4'd1) && (E_md_op <= 4'd4) && !busy;
  // Depends only on busy among registered state, so no loop through E_md_op
  assign md_stall = D_md_use & (start | busy);
  assign HI       = hi_q;
  assign LO       = lo_q;

  // Results are computed at the start edge; a zero divisor is swapped for 1
  // only to keep the arithmetic defined, the result is never committed
  always_comb begin
    prod_s     = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    prod_u     = {32'd0, E_A} * {32'd0, E_B};
    divisor_nz = (E_B == 32'd0) ? 32'd1 : E_B;
    quot_s     = $signed(E_A) / $signed(divisor_nz);
    rem_s      = $signed(E_A) % $signed(divisor_nz);
    quot_u     = E_A / divisor_nz;
    rem_u      = E_A % divisor_nz;
  end

  // Next-state: start latches the result, RUN counts down and commits at zero
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    commit_d = commit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          case (E_md_op)
            4'd1: begin
              {hi_tmp_d, lo_tmp_d} = prod_s;
              cnt_d    = CW'(MULT_CYCLES);
              commit_d = 1'b1;
            end
            4'd2: begin
              {hi_tmp_d, lo_tmp_d} = prod_u;
              cnt_d    = CW'(MULT_CYCLES);
              commit_d = 1'b1;
            end
            4'd3: begin
              hi_tmp_d = rem_s;
              lo_tmp_d = quot_s;
              cnt_d    = CW'(DIV_CYCLES);
              commit_d = (E_B != 32'd0);
            end
            default: begin
              hi_tmp_d = rem_u;
              lo_tmp_d = quot_u;
              cnt_d    = CW'(DIV_CYCLES);
              commit_d = (E_B != 32'd0);
            end
          endcase
        end else if (E_md_op == 4'd5) begin
          hi_d = E_A;
        end else if (E_md_op == 4'd6) begin
          lo_d = E_A;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (commit_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      commit_q <= commit_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_A, E_B;
  logic        D_md_use;
  logic        busy, md_stall;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_bad = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_md_op(E_md_op), .E_A(E_A), .E_B(E_B),
    .D_md_use(D_md_use), .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one md op, check busy/stall/HI/LO through the run; an extra op is
  // injected at busy cycle 1 and a mult at busy cycle 3, both must be ignored
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [3:0] inj_op,
                        input logic [31:0] inj_a, input logic [31:0] old_hi,
                        input logic [31:0] old_lo, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    @(negedge clk);
    E_md_op = op; E_A = a; E_B = b; D_md_use = 1'b1;
    #1;
    chk({tag, " start stall"}, md_stall, 1);
    chk({tag, " start busy"}, busy, 0);
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      E_md_op  = (i == 1) ? inj_op : ((i == 3) ? 4'd1 : 4'd0);
      E_A      = inj_a;
      E_B      = inj_a;
      D_md_use = (i % 2 == 0);
      #1;
      chk($sformatf("%s busy c%0d", tag, i), busy, 1);
      chk($sformatf("%s stall c%0d", tag, i), md_stall, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s HI hold c%0d", tag, i), HI, old_hi);
      chk($sformatf("%s LO hold c%0d", tag, i), LO, old_lo);
      @(posedge clk);
    end
    @(negedge clk);
    E_md_op = 4'd0; D_md_use = 1'b1;
    #1;
    chk({tag, " done busy"}, busy, 0);
    chk({tag, " done stall"}, md_stall, 0);
    chk({tag, " HI"}, HI, exp_hi);
    chk({tag, " LO"}, LO, exp_lo);
  endtask

  initial begin
    reset = 1'b1; E_md_op = 4'd0; E_A = '0; E_B = '0; D_md_use = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; D_md_use = 1'b1;
    #1;
    chk("rst busy", busy, 0);
    chk("rst HI", HI, 0);
    chk("rst LO", LO, 0);
    chk("rst stall", md_stall, 0);

    // mthi while idle
    @(negedge clk);
    E_md_op = 4'd5; E_A = 32'h0000ABCD;
    #1;
    chk("mthi stall", md_stall, 0);
    @(negedge clk);
    E_md_op = 4'd0;
    #1;
    chk("mthi HI", HI, 32'h0000ABCD);
    chk("mthi LO", LO, 0);
    chk("mthi busy", busy, 0);

    run_op("mult", 4'd1, 32'hFFFFFFFD, 32'd5, 5, 4'd0, 32'h0,
           32'h0000ABCD, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 5, 4'd0, 32'h0,
           32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000001, 32'hFFFFFFFE);
    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 4'd0, 32'h0,
           32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 4'd4, 32'd7, 32'd2, 10, 4'd6, 32'h00005555,
           32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd3);

    // Preload HI/LO, then divide by zero
    @(negedge clk);
    E_md_op = 4'd5; E_A = 32'h11;
    @(negedge clk);
    E_md_op = 4'd6; E_A = 32'h22;
    @(negedge clk);
    E_md_op = 4'd0;
    #1;
    chk("pre HI", HI, 32'h11);
    chk("pre LO", LO, 32'h22);
    run_op("div0", 4'd3, 32'd5, 32'd0, 10, 4'd5, 32'h00009999,
           32'h11, 32'h22, 32'h11, 32'h22);

    // Reset held 2 cycles in the middle of a divide
    @(negedge clk);
    E_md_op = 4'd3; E_A = 32'd100; E_B = 32'd7;
    @(negedge clk);
    E_md_op = 4'd0;
    #1;
    chk("mid busy", busy, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst HI", HI, 0);
    chk("mid rst LO", LO, 0);
    repeat (12) @(negedge clk);
    #1;
    chk("late busy", busy, 0);
    chk("late HI", HI, 0);
    chk("late LO", LO, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
